// File: rtl/mips_pkg.sv
// Shared types and constants for the fetch slice.
// FSM state, word width and IF/ID bundle.
package mips_pkg;

  localparam int WORD_W      = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_FAULT
  } fetch_state_t;

  typedef struct packed {
    logic              valid;
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
  } if_id_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory bus between fetch and imem.
// Read data is combinational from the address.
interface instr_fetch_if;
  import mips_pkg::*;

  logic [WORD_W-1:0] mem_addr;
  logic              mem_read;
  logic [WORD_W-1:0] mem_data;

  modport master (
    output mem_addr,
    output mem_read,
    input  mem_data
  );

  modport slave (
    input  mem_addr,
    input  mem_read,
    output mem_data
  );

endinterface

// File: rtl/fetch_ctrl.sv
// Fetch control FSM: BOOT -> RUN, sticky FAULT.
// Produces load, memory read strobe and flush/jump.
module fetch_ctrl
  import mips_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       redirect_valid,
  input  logic [1:0] redirect_lsb,
  input  logic       if_valid,
  input  logic       id_ready,
  output logic       load,
  output logic       mem_read,
  output logic       flush,
  output logic       jump,
  output logic       fault
);

  fetch_state_t state, state_nxt;

  // State register, synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) state <= ST_BOOT;
    else        state <= state_nxt;
  end

  // Next state and control outputs.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    mem_read  = 1'b0;
    flush     = 1'b0;
    jump      = 1'b0;
    fault     = 1'b0;
    unique case (state)
      ST_BOOT: begin
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        load     = !if_valid || id_ready;
        mem_read = load && RST_N;
      end
      ST_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        state_nxt = ST_BOOT;
      end
    endcase
    if (state != ST_FAULT && redirect_valid) begin
      flush = 1'b1;
      unique case (1'b1)
        (redirect_lsb == 2'b00): begin
          jump      = 1'b1;
          state_nxt = ST_RUN;
        end
        (redirect_lsb != 2'b00): begin
          state_nxt = ST_FAULT;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: pc, IF/ID register, counter.
// Redirect wins over load; load wins over stall.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h00000000
) (
  input  logic              CLK,
  input  logic              RST_N,
  instr_fetch_if.master     bus,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  input  logic              id_ready,
  output logic              if_valid,
  output logic [WORD_W-1:0] if_instr,
  output logic [WORD_W-1:0] if_pc,
  output logic [WORD_W-1:0] if_pc_plus4,
  output logic              fault,
  output logic [WORD_W-1:0] fetch_count
);

  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] cnt;
  if_id_t            ifid;
  logic              load;
  logic              rd;
  logic              flush;
  logic              jump;

  fetch_ctrl u_ctrl (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .redirect_valid (redirect_valid),
    .redirect_lsb   (redirect_pc[1:0]),
    .if_valid       (ifid.valid),
    .id_ready       (id_ready),
    .load           (load),
    .mem_read       (rd),
    .flush          (flush),
    .jump           (jump),
    .fault          (fault)
  );

  assign bus.mem_addr = pc;
  assign bus.mem_read = rd;

  assign if_valid    = ifid.valid;
  assign if_instr    = ifid.instr;
  assign if_pc       = ifid.pc;
  assign if_pc_plus4 = ifid.pc + WORD_W'(INSTR_BYTES);
  assign fetch_count = cnt;

  // pc, IF/ID register and fetch counter update.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pc   <= RESET_PC;
      ifid <= '0;
      cnt  <= '0;
    end else if (flush) begin
      ifid.valid <= 1'b0;
      if (jump) pc <= redirect_pc;
    end else if (load) begin
      ifid.valid <= 1'b1;
      ifid.instr <= bus.mem_data;
      ifid.pc    <= pc;
      pc         <= pc + WORD_W'(INSTR_BYTES);
      cnt        <= cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a small ROM.
// Second instance checks the wrapping reset pc.
module tb_instr_fetch;

  logic        CLK;
  logic        RST_N;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;

  logic        if_valid, fault;
  logic [31:0] if_instr, if_pc, if_pc_plus4, fetch_count;
  logic        if_valid2, fault2;
  logic [31:0] if_instr2, if_pc2, if_pc_plus42, fetch_count2;

  logic [31:0] rom [16];
  int passed = 0;
  int total  = 0;

  instr_fetch_if bus1 ();
  instr_fetch_if bus2 ();

  assign bus1.mem_data = rom[bus1.mem_addr[5:2]];
  assign bus2.mem_data = rom[bus2.mem_addr[5:2]];

  instr_fetch dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .bus            (bus1),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .fault          (fault),
    .fetch_count    (fetch_count)
  );

  instr_fetch #(.RESET_PC(32'hFFFFFFFC)) dut2 (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .bus            (bus2),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_valid       (if_valid2),
    .if_instr       (if_instr2),
    .if_pc          (if_pc2),
    .if_pc_plus4    (if_pc_plus42),
    .fault          (fault2),
    .fetch_count    (fetch_count2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 32'h0;
    rom[0]  = 32'h00000820;
    rom[1]  = 32'h2003000A;
    rom[2]  = 32'h00001020;
    rom[3]  = 32'h20420001;
    rom[4]  = 32'h00221820;
    rom[15] = 32'h8C010000;

    RST_N = 1'b0;
    id_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    step();
    step();
    chk("rst_valid", if_valid, 0);
    chk("rst_instr", if_instr, 0);
    chk("rst_pc", if_pc, 0);
    chk("rst_fault", fault, 0);
    chk("rst_cnt", fetch_count, 0);
    chk("rst_rd", bus1.mem_read, 0);
    chk("rst_addr", bus1.mem_addr, 0);
    chk("rst_addr2", bus2.mem_addr, 32'hFFFFFFFC);

    RST_N = 1'b1;
    #1;
    chk("boot_rd", bus1.mem_read, 0);
    step();
    chk("boot_noload", if_valid, 0);
    chk("run_rd", bus1.mem_read, 1);
    chk("run_addr", bus1.mem_addr, 0);

    step();
    chk("ld0_instr", if_instr, 32'h00000820);
    chk("ld0_pc", if_pc, 0);
    chk("ld0_cnt", fetch_count, 1);
    chk("ld0_addr", bus1.mem_addr, 4);
    chk("wrap_pc", if_pc2, 32'hFFFFFFFC);
    chk("wrap_p4", if_pc_plus42, 0);
    chk("wrap_instr", if_instr2, 32'h8C010000);
    chk("wrap_addr", bus2.mem_addr, 0);

    step();
    chk("ld1_instr", if_instr, 32'h2003000A);
    chk("ld1_pc", if_pc, 4);
    chk("ld1_cnt", fetch_count, 2);

    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stl_instr", if_instr, 32'h2003000A);
      chk("stl_pc", if_pc, 4);
      chk("stl_addr", bus1.mem_addr, 8);
      chk("stl_cnt", fetch_count, 2);
      chk("stl_rd", bus1.mem_read, 0);
    end

    id_ready = 1'b1;
    step();
    chk("ld2_instr", if_instr, 32'h00001020);
    chk("ld2_pc", if_pc, 8);
    chk("ld2_p4", if_pc_plus4, 32'hC);
    chk("ld2_cnt", fetch_count, 3);

    step();
    chk("ld3_instr", if_instr, 32'h20420001);
    chk("ld3_cnt", fetch_count, 4);
    chk("ld3_addr", bus1.mem_addr, 32'h10);

    id_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000000C;
    step();
    redirect_valid = 1'b0;
    chk("rd_flush", if_valid, 0);
    chk("rd_cnt", fetch_count, 4);
    chk("rd_addr", bus1.mem_addr, 32'hC);
    #1;
    chk("rd_rd", bus1.mem_read, 1);
    step();
    chk("rd_valid", if_valid, 1);
    chk("rd_instr", if_instr, 32'h20420001);
    chk("rd_pc", if_pc, 32'hC);
    chk("rd_cnt2", fetch_count, 5);

    id_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000000E;
    step();
    chk("flt_fault", fault, 1);
    chk("flt_rd", bus1.mem_read, 0);
    chk("flt_valid", if_valid, 0);
    chk("flt_addr", bus1.mem_addr, 32'h10);
    redirect_pc = 32'h0;
    step();
    chk("flt_sticky", fault, 1);
    chk("flt_addr2", bus1.mem_addr, 32'h10);
    chk("flt_cnt", fetch_count, 5);
    redirect_valid = 1'b0;
    step();
    chk("flt_rd2", bus1.mem_read, 0);
    chk("flt_valid2", if_valid, 0);
    RST_N = 1'b0;
    step();
    chk("flt_clr", fault, 0);
    chk("flt_clr_cnt", fetch_count, 0);

    RST_N = 1'b1;
    step();
    step();
    step();
    chk("re_instr", if_instr, 32'h2003000A);
    id_ready = 1'b0;
    step();
    chk("ms_valid", if_valid, 1);
    RST_N = 1'b0;
    step();
    chk("ms_valid0", if_valid, 0);
    chk("ms_instr0", if_instr, 0);
    chk("ms_pc0", if_pc, 0);
    chk("ms_cnt0", fetch_count, 0);
    chk("ms_fault0", fault, 0);
    chk("ms_addr0", bus1.mem_addr, 0);
    chk("ms_rd0", bus1.mem_read, 0);
    RST_N = 1'b1;
    id_ready = 1'b1;
    #1;
    chk("ms_boot_rd", bus1.mem_read, 0);
    step();
    chk("ms_run_rd", bus1.mem_read, 1);
    step();
    chk("ms_instr", if_instr, 32'h00000820);
    chk("ms_pc", if_pc, 0);
    chk("ms_cnt", fetch_count, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
